// File: rtl/data_mem_responder.sv
// Byte-addressed data memory responder for an RV32I load/store unit.
// Accepts one request at a time (valid/ready), waits LATENCY cycles, performs
// the access on the edge entering RESP and holds the response until taken.
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready, req_write, req_funct3, req_addr, req_wdata  : request
//   resp_valid/resp_ready, resp_rdata, resp_err                      : response
module data_mem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_ready_q, req_ready_d;
  logic          write_q, write_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [7:0]    addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  // Storage is deliberately not reset.
  logic [7:0]    mem [DEPTH];

  logic          acc_write;
  logic [2:0]    acc_funct3;
  logic [7:0]    acc_addr;
  logic [31:0]   acc_wdata;
  logic [2:0]    acc_size;
  logic          acc_sext;
  logic          acc_legal;
  logic          acc_misal;
  logic          acc_err;
  logic [AW-1:0] idx [4];
  logic [7:0]    rbyte [4];
  logic [3:0]    byte_en;
  logic [31:0]   load_data;
  logic          enter_resp;
  logic          mem_we;

  // Request seen by the access logic: live inputs while IDLE (a LATENCY=0
  // access happens on the accept edge itself), the latched copy otherwise.
  always_comb begin
    if (state_q == IDLE) begin
      acc_write  = req_write;
      acc_funct3 = req_funct3;
      acc_addr   = req_addr;
      acc_wdata  = req_wdata;
    end else begin
      acc_write  = write_q;
      acc_funct3 = funct3_q;
      acc_addr   = addr_q;
      acc_wdata  = wdata_q;
    end
  end

  // Size/sign decode and error classification.
  always_comb begin
    acc_size  = 3'd1;
    acc_sext  = 1'b0;
    acc_legal = 1'b0;
    case (acc_funct3)
      3'b000: begin acc_size = 3'd1; acc_sext = 1'b1; acc_legal = 1'b1;       end
      3'b001: begin acc_size = 3'd2; acc_sext = 1'b1; acc_legal = 1'b1;       end
      3'b010: begin acc_size = 3'd4; acc_sext = 1'b0; acc_legal = 1'b1;       end
      3'b100: begin acc_size = 3'd1; acc_sext = 1'b0; acc_legal = !acc_write; end
      3'b101: begin acc_size = 3'd2; acc_sext = 1'b0; acc_legal = !acc_write; end
      default: ;
    endcase
    acc_misal = ((acc_size == 3'd2) && acc_addr[0]) ||
                ((acc_size == 3'd4) && (acc_addr[1:0] != 2'b00));
    acc_err   = !acc_legal || acc_misal;
  end

  // Byte lanes: lane k maps to address A+k (little-endian), modulo DEPTH.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      idx[k]     = acc_addr[AW-1:0] + AW'(k);
      rbyte[k]   = mem[idx[k]];
      byte_en[k] = 3'(k) < acc_size;
    end
  end

  // Load extension.
  always_comb begin
    case (acc_size)
      3'd1:    load_data = acc_sext ? {{24{rbyte[0][7]}}, rbyte[0]}
                                    : {24'h0, rbyte[0]};
      3'd2:    load_data = acc_sext ? {{16{rbyte[1][7]}}, rbyte[1], rbyte[0]}
                                    : {16'h0, rbyte[1], rbyte[0]};
      default: load_data = {rbyte[3], rbyte[2], rbyte[1], rbyte[0]};
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    enter_resp   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CW'(LATENCY);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          rdata_d      = '0;
          err_d        = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      resp_valid_d = 1'b1;
      err_d        = acc_err;
      rdata_d      = (acc_err || acc_write) ? '0 : load_data;
    end

    mem_we      = enter_resp && acc_write && !acc_err;
    // Ready follows the state being entered, so it rises the cycle after RESP exits.
    req_ready_d = (state_d == IDLE);
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      write_q      <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      write_q      <= write_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Byte-enabled store.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (mem_we && byte_en[k]) begin
        mem[idx[k]] <= acc_wdata[8*k +: 8];
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder (DEPTH=256, LATENCY=2):
// directed vector table, multi-cycle corner sequences, and randomized traffic
// against a byte-array reference model.
module tb_data_mem_responder;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_mem [256];

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [$];

  data_mem_responder #(.DEPTH(256), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, 64'(req_ready), 64'd1);
  endtask

  // One full transaction; resp_ready is held low for 'hold' cycles in RESP.
  task automatic txn(input logic w, input logic [2:0] f3, input logic [7:0] a,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic er);
    int n;
    wait_ready("txn_ready");
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    resp_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    // Junk on the request bus after acceptance must be ignored.
    req_valid  = 1'($urandom_range(0, 1));
    req_write  = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = 8'($urandom_range(0, 255));
    req_wdata  = $urandom;
    n = 0;
    while (resp_valid !== 1'b1 && n < 40) begin
      resp_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'(LAT));
    req_valid = 1'b0;
    rd = resp_rdata;
    er = resp_err;
    for (int i = 0; i < hold; i++) begin
      resp_ready = 1'b0;
      @(posedge clk); #1;
      chk("resp_hold", {resp_valid, req_ready, resp_err, resp_rdata}, {1'b1, 1'b0, er, rd});
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_leave", {resp_valid, req_ready}, 64'b01);
  endtask

  // Reference: access rules applied to a plain byte array.
  task automatic model_access(input logic w, input logic [2:0] f3, input logic [7:0] a,
                              input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int     size = 0;
    bit     sgn  = 0;
    longint v    = 0;
    if (f3 == 3'd0)            begin size = 1; sgn = 1; end
    else if (f3 == 3'd1)       begin size = 2; sgn = 1; end
    else if (f3 == 3'd2)       begin size = 4; end
    else if (f3 == 3'd4 && !w) begin size = 1; end
    else if (f3 == 3'd5 && !w) begin size = 2; end
    if (size == 0) er = 1'b1;
    else           er = (int'(a) % size) != 0;
    rd = '0;
    if (!er) begin
      if (w) begin
        for (int k = 0; k < size; k++)
          model_mem[(int'(a) + k) % 256] = 8'((wd >> (8 * k)) & 32'hFF);
      end else begin
        for (int k = 0; k < size; k++)
          v += longint'(model_mem[(int'(a) + k) % 256]) << (8 * k);
        if (sgn && v >= (64'sd1 << (8 * size - 1)))
          v -= (64'sd1 << (8 * size));
        rd = v[31:0];
      end
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [2:0] f3, input logic [7:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input logic er);
    vec_t v;
    v.w = w; v.f3 = f3; v.a = a; v.wd = wd; v.exp_rd = rd; v.exp_err = er;
    return v;
  endfunction

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] exp_rd;
    logic        exp_er;
    int          n;

    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

    vecs.push_back(mk(1, 3'b010, 8'h10, 32'hDEADBEEF, 32'h0,        0));
    vecs.push_back(mk(0, 3'b010, 8'h10, 32'h0,        32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 3'b000, 8'h13, 32'h0,        32'hFFFFFFDE, 0));
    vecs.push_back(mk(0, 3'b100, 8'h13, 32'h0,        32'h000000DE, 0));
    vecs.push_back(mk(0, 3'b001, 8'h12, 32'h0,        32'hFFFFDEAD, 0));
    vecs.push_back(mk(0, 3'b101, 8'h10, 32'h0,        32'h0000BEEF, 0));
    vecs.push_back(mk(1, 3'b000, 8'h11, 32'h00000055, 32'h0,        0));
    vecs.push_back(mk(0, 3'b010, 8'h10, 32'h0,        32'hDEAD55EF, 0));
    vecs.push_back(mk(1, 3'b010, 8'h12, 32'h01020304, 32'h0,        1));
    vecs.push_back(mk(0, 3'b001, 8'h11, 32'h0,        32'h0,        1));
    vecs.push_back(mk(1, 3'b100, 8'h10, 32'h0000FFFF, 32'h0,        1));
    vecs.push_back(mk(1, 3'b101, 8'h10, 32'h0000FFFF, 32'h0,        1));
    vecs.push_back(mk(0, 3'b011, 8'h10, 32'h0,        32'h0,        1));
    vecs.push_back(mk(1, 3'b110, 8'h10, 32'hFFFFFFFF, 32'h0,        1));
    vecs.push_back(mk(0, 3'b111, 8'h10, 32'h0,        32'h0,        1));
    vecs.push_back(mk(0, 3'b101, 8'h13, 32'h0,        32'h0,        1));
    vecs.push_back(mk(0, 3'b010, 8'h11, 32'h0,        32'h0,        1));
    vecs.push_back(mk(0, 3'b010, 8'h10, 32'h0,        32'hDEAD55EF, 0));
    vecs.push_back(mk(1, 3'b010, 8'h14, 32'h11223344, 32'h0,        0));
    vecs.push_back(mk(1, 3'b001, 8'h16, 32'hFFFFA5A5, 32'h0,        0));
    vecs.push_back(mk(0, 3'b010, 8'h14, 32'h0,        32'hA5A53344, 0));
    vecs.push_back(mk(0, 3'b000, 8'h15, 32'h0,        32'h00000033, 0));
    vecs.push_back(mk(0, 3'b001, 8'h16, 32'h0,        32'hFFFFA5A5, 0));
    vecs.push_back(mk(1, 3'b010, 8'hFC, 32'hCAFEF00D, 32'h0,        0));
    vecs.push_back(mk(0, 3'b100, 8'hFF, 32'h0,        32'h000000CA, 0));
    vecs.push_back(mk(0, 3'b001, 8'hFE, 32'h0,        32'hFFFFCAFE, 0));
    vecs.push_back(mk(0, 3'b000, 8'hFC, 32'h0,        32'h0000000D, 0));
    vecs.push_back(mk(0, 3'b010, 8'hFC, 32'h0,        32'hCAFEF00D, 0));

    // Reset values, then ready on the first cycle after release.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {req_ready, resp_valid, resp_err, resp_rdata}, 64'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", {req_ready, resp_valid}, 64'b10);

    // Reset during BUSY discards the pending store.
    wait_ready("busy_rst_ready");
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 8'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("busy_rst_outputs", {req_ready, resp_valid, resp_err, resp_rdata}, 64'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("busy_rst_release", {req_ready, resp_valid}, 64'b10);
    txn(1'b0, 3'b010, 8'h20, 32'h0, 0, rd, er);
    chk("busy_rst_discard", 64'(rd == 32'h12345678), 64'd0);

    // Directed table.
    foreach (vecs[i]) begin
      txn(vecs[i].w, vecs[i].f3, vecs[i].a, vecs[i].wd, i % 3, rd, er);
      if (rd !== vecs[i].exp_rd)
        $display("FAIL vec%0d_rdata actual=%h expected=%h", i, rd, vecs[i].exp_rd);
      if (er !== vecs[i].exp_err)
        $display("FAIL vec%0d_err actual=%b expected=%b", i, er, vecs[i].exp_err);
      total += 2;
      bad += int'(rd !== vecs[i].exp_rd) + int'(er !== vecs[i].exp_err);
    end

    // Response held for 5 cycles while the request side toggles.
    wait_ready("hold_ready");
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 8'h10;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    n = 0;
    while (resp_valid !== 1'b1 && n < 40) begin
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      n++;
    end
    chk("hold_latency", 64'(n), 64'(LAT));
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      chk("hold_stable", {resp_valid, req_ready, resp_err, resp_rdata},
          {1'b1, 1'b0, 1'b0, 32'hDEAD55EF});
    end
    // Leaving RESP with a request pending must not accept it on that edge.
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 8'h14;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("leave_no_accept", {resp_valid, req_ready}, 64'b01);
    req_valid = 1'b0; resp_ready = 1'b0;

    // Reset during RESP keeps the committed store.
    wait_ready("resp_rst_ready");
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 8'h30; req_wdata = 32'hA1B2C3D4; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (resp_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("resp_rst_reached", 64'(resp_valid), 64'd1);
    rst = 1'b0;
    #1;
    chk("resp_rst_outputs", {req_ready, resp_valid, resp_err, resp_rdata}, 64'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 3'b010, 8'h30, 32'h0, 0, rd, er);
    chk("resp_rst_kept", {er, rd}, {1'b0, 32'hA1B2C3D4});

    // Fill memory so the model knows every byte, then random traffic.
    for (int a = 0; a < 256; a++) begin
      logic [31:0] wd;
      wd = $urandom;
      model_access(1'b1, 3'b000, 8'(a), wd, exp_rd, exp_er);
      txn(1'b1, 3'b000, 8'(a), wd, 0, rd, er);
      if (a % 64 == 0) chk("fill_err", 64'(er), 64'(exp_er));
    end
    for (int t = 0; t < 300; t++) begin
      logic        w;
      logic [2:0]  f3;
      logic [7:0]  a;
      logic [31:0] wd;
      logic [2:0]  legal_f3 [5];
      legal_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      w  = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 3) != 0) ? legal_f3[$urandom_range(0, 4)]
                                       : 3'($urandom_range(0, 7));
      a  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      wd = $urandom;
      model_access(w, f3, a, wd, exp_rd, exp_er);
      txn(w, f3, a, wd, int'($urandom_range(0, 3)), rd, er);
      chk($sformatf("rand%0d_w%0d_f%0d_a%02h", t, w, f3, a), {er, rd}, {exp_er, exp_rd});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Parameters
REQ-001 The block SHALL have parameter DEPTH, default 256, giving the memory size in bytes, which SHALL be a power of two no larger than 256.
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the wait cycles between request acceptance and response; the legal range SHALL be 0..15.

Interface
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RV32I size/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-009 req_addr  input  8  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  initiator takes the response.
REQ-013 resp_rdata  output  32  load data, extended per funct3; 0 for stores and errors.
REQ-014 resp_err  output  1  misaligned or illegal request.

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1, latching req_write, req_funct3, req_addr and req_wdata.
REQ-018 On acceptance, the FSM SHALL go to BUSY with wait counter = LATENCY if LATENCY>0, or directly to RESP if LATENCY=0.
REQ-019 In BUSY, the counter SHALL decrement once per cycle; the edge at which the counter equals 1 SHALL move the FSM to RESP.
REQ-020 Latency: resp_valid SHALL first be sampled high at accept edge + LATENCY + 1.
REQ-021 The memory access SHALL be performed on the edge entering RESP; resp_rdata and resp_err SHALL be registered on that same edge.
REQ-022 resp_valid, resp_rdata and resp_err SHALL be held stable while in RESP.
REQ-023 The FSM SHALL leave RESP for IDLE on an edge with resp_ready=1.
REQ-024 A new request SHALL NOT be accepted on that same edge; req_ready SHALL rise on the next cycle.
REQ-025 Byte order SHALL be little-endian: byte k of the word goes to address A+k.
REQ-026 Stores SHALL write 1, 2 or 4 bytes for sb, sh or sw, using the low bytes of wdata; unaffected bytes SHALL be unchanged.
REQ-027 Loads: lb and lh SHALL sign-extend; lbu and lhu SHALL zero-extend; lw SHALL return the full 32-bit word.
REQ-028 Misalignment: a halfword access with addr[0]=1, or a word access with addr[1:0]≠00, SHALL set resp_err=1, write nothing and return resp_rdata=0.
REQ-029 Illegal funct3: 011, 110 or 111 on any access, and 100 or 101 on a store, SHALL set resp_err=1 with no memory effect.
REQ-030 The address SHALL be reduced modulo DEPTH, using only the low log2(DEPTH) bits.
REQ-031 An aligned access SHALL never straddle the top of memory.
REQ-032 req_valid toggling while not ready SHALL have no effect; changes to the request inputs after acceptance SHALL be ignored.
REQ-033 resp_ready=1 outside RESP SHALL be ignored.

Reset
REQ-034 rst=0 SHALL asynchronously force state=IDLE, counter=0, resp_valid=0, resp_rdata=0 and resp_err=0.
REQ-035 req_ready SHALL be 0 while rst=0 and SHALL be 1 on the first cycle after release.
REQ-036 Memory contents SHALL NOT be reset and SHALL be undefined at power-up.
REQ-037 If reset is asserted in BUSY, the pending store SHALL be discarded and no bytes written.
REQ-038 If reset is asserted in RESP, the response SHALL be dropped and the already-committed store SHALL remain.

Verification
REQ-039 With LATENCY=2, sw addr 0x10 wdata 0xDEADBEEF, then lw 0x10 -> resp_valid at accept+3, rdata=0xDEADBEEF, err=0.
REQ-040 After REQ-039, lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x12 -> 0xFFFFDEAD; lhu 0x10 -> 0x0000BEEF.
REQ-041 sb 0x11 wdata 0x55, then lw 0x10 -> 0xDEAD55EF.
REQ-042 sw 0x12, lh 0x11, and sh with funct3=100 -> err=1, rdata=0; then lw 0x10 still returns 0xDEAD55EF.
REQ-043 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, rdata and err stay constant and req_ready=0; with resp_ready=1 -> IDLE next cycle.
REQ-044 Accept sw 0x20 wdata 0x12345678 and pulse rst low during BUSY -> all outputs reset, req_ready=1 after release; a later lw 0x20 does not return 0x12345678 unless previously written.
